// File: rtl/parity_serial_rx.sv
// parity_serial_rx
// Even-parity serial frame receiver: start / DATA_BITS (LSB first) / parity / stop.
// Samples each bit mid-period, recomputes parity over the received bits and
// reports parity and framing errors alongside each completed word.
module parity_serial_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    state_t               state, state_nxt;
    logic                 rx_meta, rxs;
    logic [CNT_W-1:0]     clk_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;

    logic                 cnt_clr;
    logic                 data_smp;
    logic                 par_smp;
    logic                 stop_smp;

    // Two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rxs     <= rx_meta;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and sample strobes; every bit period ends on a cleared counter
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        data_smp  = 1'b0;
        par_smp   = 1'b0;
        stop_smp  = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!rxs) state_nxt = START;
            end
            START: begin
                if (clk_cnt == HALF_CNT) begin
                    cnt_clr   = 1'b1;
                    state_nxt = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt == LAST_CNT) begin
                    cnt_clr  = 1'b1;
                    data_smp = 1'b1;
                    if (bit_idx == LAST_IDX) state_nxt = PARITY;
                end
            end
            PARITY: begin
                if (clk_cnt == LAST_CNT) begin
                    cnt_clr   = 1'b1;
                    par_smp   = 1'b1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                // Leaving mid-stop-bit lets a start bit right after the stop bit be caught
                if (clk_cnt == LAST_CNT) begin
                    cnt_clr   = 1'b1;
                    stop_smp  = 1'b1;
                    state_nxt = rxs ? IDLE : BREAK;
                end
            end
            BREAK: begin
                cnt_clr = 1'b1;
                if (rxs) state_nxt = IDLE;
            end
            default: begin
                cnt_clr   = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    // Bit-period counter and data bit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt <= '0;
            bit_idx <= '0;
        end else begin
            if (cnt_clr) clk_cnt <= '0;
            else         clk_cnt <= clk_cnt + 1'b1;

            if (state != DATA)  bit_idx <= '0;
            else if (data_smp)  bit_idx <= bit_idx + 1'b1;
        end
    end

    // Deserializer and parity-bit capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            if (data_smp) shreg[bit_idx] <= rxs;
            if (par_smp)  par_bit        <= rxs;
        end
    end

    // Output registers, updated only on the stop-bit sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid <= stop_smp;
            if (stop_smp) begin
                rx_data    <= shreg;
                parity_err <= (^shreg) ^ par_bit;
                frame_err  <= ~rxs;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_parity_serial_rx.sv
// Directed bench for parity_serial_rx: frames are driven on the pin, expected
// results are queued at send time and checked when rx_valid pulses.
module tb_parity_serial_rx;

    localparam int CPB = 16;
    localparam int DB  = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_in = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          parity_err;
    logic          frame_err;
    logic          busy;

    typedef struct packed {
        logic [DB-1:0] data;
        logic          perr;
        logic          ferr;
    } exp_t;

    exp_t        sb[$];
    int unsigned valid_cyc[$];
    int          compared   = 0;
    int          mismatched = 0;
    int unsigned cyc        = 0;
    int unsigned busy_rise  = 0;
    int unsigned busy_fall  = 0;
    logic        busy_prev  = 1'b0;

    parity_serial_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_in     (rx_in),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every rx_valid sample pops one expected frame
    always @(negedge clk) begin
        if (busy && !busy_prev) busy_rise = cyc;
        if (!busy && busy_prev) busy_fall = cyc;
        busy_prev = busy;
        if (rx_valid) begin
            exp_t e;
            valid_cyc.push_back(cyc);
            check("sb_nonempty", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_rx_data",    32'(rx_data),    32'(e.data));
                check("sb_parity_err", 32'(parity_err), 32'(e.perr));
                check("sb_frame_err",  32'(frame_err),  32'(e.ferr));
            end
        end
    end

    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic p, input logic s,
                              input logic exp_perr, input logic exp_ferr);
        exp_t e;
        e.data = d;
        e.perr = exp_perr;
        e.ferr = exp_ferr;
        sb.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
    endtask

    initial begin
        int unsigned n;
        int unsigned start_cyc;
        logic [DB-1:0] pat;

        // Reset state
        rst_n = 1'b0;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rx_data",    32'(rx_data),    32'h0);
        check("rst_rx_valid",   32'(rx_valid),   32'h0);
        check("rst_parity_err", 32'(parity_err), 32'h0);
        check("rst_frame_err",  32'(frame_err),  32'h0);
        check("rst_busy",       32'(busy),       32'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Good frame 0xA5, latency and busy timing
        start_cyc = cyc;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("f1_count", valid_cyc.size(), 32'd1);
        check("f1_latency", (valid_cyc.size() > 0) ? valid_cyc[0] - start_cyc : 32'd0, 32'd171);
        check("f1_busy_rise", busy_rise - start_cyc, 32'd3);
        check("f1_busy_fall", busy_fall - start_cyc, 32'd171);
        check("f1_hold_data", 32'(rx_data), 32'hA5);
        check("f1_valid_low", 32'(rx_valid), 32'h0);

        // Back-to-back frames without idle gap
        n = valid_cyc.size();
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("b2b_count", valid_cyc.size(), n + 2);
        check("b2b_spacing",
              (valid_cyc.size() >= n + 2) ? valid_cyc[n+1] - valid_cyc[n] : 32'd0, 32'd176);
        check("b2b_hold_data", 32'(rx_data), 32'h00);

        // Parity error, then cleared by a good frame
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        check("perr_hold", 32'(parity_err), 32'h1);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("perr_cleared", 32'(parity_err), 32'h0);

        // Framing error with line held low 40 cycles from the stop bit
        n = valid_cyc.size();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (40 - CPB) @(negedge clk);
        check("brk_count", valid_cyc.size(), n + 1);
        check("brk_frame_err", 32'(frame_err), 32'h1);
        check("brk_busy", 32'(busy), 32'h1);
        rx_in = 1'b1;
        repeat (6) @(negedge clk);
        check("brk_exit_busy", 32'(busy), 32'h0);
        check("brk_no_extra", valid_cyc.size(), n + 1);
        send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("ferr_cleared", 32'(frame_err), 32'h0);

        // Short glitch: false start
        n = valid_cyc.size();
        start_cyc = cyc;
        rx_in = 1'b0;
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        repeat (30) @(negedge clk);
        check("gl_busy_pulsed", (busy_rise > start_cyc) ? 32'd1 : 32'd0, 32'd1);
        check("gl_busy_low", 32'(busy), 32'h0);
        check("gl_no_valid", valid_cyc.size(), n);
        check("gl_data_kept", 32'(rx_data), 32'h81);
        check("gl_flags_kept", {30'd0, parity_err, frame_err}, 32'h0);

        // Reset during data bit 3
        n = valid_cyc.size();
        pat = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(pat[i]);
        rx_in = pat[3];
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        rx_in = 1'b1;
        repeat (2) @(negedge clk);
        check("mr_rx_data", 32'(rx_data), 32'h0);
        check("mr_busy", 32'(busy), 32'h0);
        check("mr_valid", 32'(rx_valid), 32'h0);
        check("mr_flags", {30'd0, parity_err, frame_err}, 32'h0);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("mr_no_pulse", valid_cyc.size(), n);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("mr_after_count", valid_cyc.size(), n + 1);
        check("mr_after_data", 32'(rx_data), 32'h5A);

        check("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
